// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - mode codes, RV32 opcodes and decoded-instruction record for decode_stage
package decode_pkg;

  localparam int MODE_W = 4;

  localparam logic [MODE_W-1:0] MODE_NOP     = 4'd0;
  localparam logic [MODE_W-1:0] MODE_R       = 4'd1;
  localparam logic [MODE_W-1:0] MODE_I       = 4'd2;
  localparam logic [MODE_W-1:0] MODE_LOAD    = 4'd3;
  localparam logic [MODE_W-1:0] MODE_STORE   = 4'd4;
  localparam logic [MODE_W-1:0] MODE_BRANCH  = 4'd5;
  localparam logic [MODE_W-1:0] MODE_JAL     = 4'd6;
  localparam logic [MODE_W-1:0] MODE_LUI     = 4'd7;
  localparam logic [MODE_W-1:0] MODE_AUIPC   = 4'd8;
  localparam logic [MODE_W-1:0] MODE_ILLEGAL = 4'd9;
  localparam logic [MODE_W-1:0] MODE_JALR    = 4'd10;

  localparam logic [6:0] OPC_NOP    = 7'b0000000;
  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // imm is kept at 32 bits; the stage sign-extends it to XLEN at its output
  typedef struct packed {
    logic [MODE_W-1:0] mode;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [31:0]       imm;
  } decoded_t;

endpackage

// File: rtl/decode_core.sv
// rtl/decode_core.sv - combinational RV32 classifier, field gating and immediate generation
module decode_core
  import decode_pkg::*;
(
  input  logic [31:0] instr_i,
  output decoded_t    dec_o
);

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u = {instr_i[31:12], 12'b0};
  assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

  always_comb begin
    dec_o = '0;
    case (instr_i[6:0])
      OPC_NOP: dec_o.mode = MODE_NOP;
      OPC_R: begin
        dec_o.mode   = MODE_R;
        dec_o.rd     = instr_i[11:7];
        dec_o.rs1    = instr_i[19:15];
        dec_o.rs2    = instr_i[24:20];
        dec_o.funct3 = instr_i[14:12];
        dec_o.funct7 = instr_i[31:25];
      end
      OPC_I: begin
        dec_o.mode   = MODE_I;
        dec_o.rd     = instr_i[11:7];
        dec_o.rs1    = instr_i[19:15];
        dec_o.funct3 = instr_i[14:12];
        dec_o.funct7 = instr_i[31:25];
        dec_o.imm    = imm_i;
      end
      OPC_LOAD, OPC_JALR: begin
        dec_o.mode   = (instr_i[6:0] == OPC_LOAD) ? MODE_LOAD : MODE_JALR;
        dec_o.rd     = instr_i[11:7];
        dec_o.rs1    = instr_i[19:15];
        dec_o.funct3 = instr_i[14:12];
        dec_o.imm    = imm_i;
      end
      OPC_STORE, OPC_BRANCH: begin
        dec_o.mode   = (instr_i[6:0] == OPC_STORE) ? MODE_STORE : MODE_BRANCH;
        dec_o.rs1    = instr_i[19:15];
        dec_o.rs2    = instr_i[24:20];
        dec_o.funct3 = instr_i[14:12];
        dec_o.imm    = (instr_i[6:0] == OPC_STORE) ? imm_s : imm_b;
      end
      OPC_JAL: begin
        dec_o.mode = MODE_JAL;
        dec_o.rd   = instr_i[11:7];
        dec_o.imm  = imm_j;
      end
      OPC_LUI, OPC_AUIPC: begin
        dec_o.mode = (instr_i[6:0] == OPC_LUI) ? MODE_LUI : MODE_AUIPC;
        dec_o.rd   = instr_i[11:7];
        dec_o.imm  = imm_u;
      end
      default: dec_o.mode = MODE_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered RV32 decode stage with skid buffer; DECODE_STATS_EN adds handshake counters
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [XLEN-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MODE_W-1:0] out_mode,
  output logic [4:0]        out_rd,
  output logic [4:0]        out_rs1,
  output logic [4:0]        out_rs2,
  output logic [2:0]        out_funct3,
  output logic [6:0]        out_funct7,
  output logic [XLEN-1:0]   out_imm,
  output logic [XLEN-1:0]   out_pc,
  output logic              out_illegal
`ifdef DECODE_STATS_EN
  ,
  output logic [CNT_W-1:0]  stat_decoded,
  output logic [CNT_W-1:0]  stat_illegal
`endif
);

  if (XLEN < 32) begin : g_xlen_check
    $error("decode_stage: XLEN must be >= 32");
  end
  if (CNT_W < 1) begin : g_cnt_check
    $error("decode_stage: CNT_W must be >= 1");
  end

  decoded_t          in_dec;
  decoded_t          out_q, out_d, skid_q, skid_d;
  logic [XLEN-1:0]   out_pc_q, out_pc_d, skid_pc_q, skid_pc_d;
  logic              out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
  logic              in_ready_q, in_ready_d;
  logic              in_hs, out_load;

  decode_core u_core (
    .instr_i (in_instr),
    .dec_o   (in_dec)
  );

  // The skid only fills while the output is stalled, so an occupied skid
  // implies a valid output; draining it always wins over new input.
  always_comb begin
    in_hs        = in_valid && in_ready_q;
    out_load     = !out_valid_q || out_ready;
    out_d        = out_q;
    out_pc_d     = out_pc_q;
    skid_d       = skid_q;
    skid_pc_d    = skid_pc_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      if (out_load) begin
        out_d        = skid_q;
        out_pc_d     = skid_pc_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end
    end else if (out_load) begin
      out_valid_d = in_hs;
      if (in_hs) begin
        out_d    = in_dec;
        out_pc_d = in_pc;
      end
    end else if (in_hs) begin
      skid_d       = in_dec;
      skid_pc_d    = in_pc;
      skid_valid_d = 1'b1;
    end
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q        <= '0;
      out_pc_q     <= '0;
      skid_q       <= '0;
      skid_pc_q    <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      out_q        <= out_d;
      out_pc_q     <= out_pc_d;
      skid_q       <= skid_d;
      skid_pc_q    <= skid_pc_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_mode    = out_q.mode;
  assign out_rd      = out_q.rd;
  assign out_rs1     = out_q.rs1;
  assign out_rs2     = out_q.rs2;
  assign out_funct3  = out_q.funct3;
  assign out_funct7  = out_q.funct7;
  assign out_imm     = XLEN'($signed(out_q.imm));
  assign out_pc      = out_pc_q;
  assign out_illegal = (out_q.mode == MODE_ILLEGAL);

`ifdef DECODE_STATS_EN
  logic [CNT_W-1:0] stat_decoded_q, stat_illegal_q;

  // Saturating; deliberately untouched by flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_decoded_q <= '0;
      stat_illegal_q <= '0;
    end else if (out_valid_q && out_ready) begin
      if (!(&stat_decoded_q)) stat_decoded_q <= stat_decoded_q + CNT_W'(1);
      if (out_illegal && !(&stat_illegal_q)) stat_illegal_q <= stat_illegal_q + CNT_W'(1);
    end
  end

  assign stat_decoded = stat_decoded_q;
  assign stat_illegal = stat_illegal_q;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - randomized and directed bench for decode_stage against a queue-based reference model
module tb_decode_stage;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst, flush, in_valid, out_ready;
  logic             in_ready, out_valid, out_illegal;
  logic [31:0]      in_instr;
  logic [XLEN-1:0]  in_pc, out_imm, out_pc;
  logic [3:0]       out_mode;
  logic [4:0]       out_rd, out_rs1, out_rs2;
  logic [2:0]       out_funct3;
  logic [6:0]       out_funct7;
`ifdef DECODE_STATS_EN
  logic [CNT_W-1:0] stat_decoded, stat_illegal;
`endif

  always #5 clk = ~clk;

  decode_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_mode    (out_mode),
    .out_rd      (out_rd),
    .out_rs1     (out_rs1),
    .out_rs2     (out_rs2),
    .out_funct3  (out_funct3),
    .out_funct7  (out_funct7),
    .out_imm     (out_imm),
    .out_pc      (out_pc),
    .out_illegal (out_illegal)
`ifdef DECODE_STATS_EN
    ,
    .stat_decoded (stat_decoded),
    .stat_illegal (stat_illegal)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int          mode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] pc;
  } exp_t;

  exp_t q[$];
  int   exp_dec = 0;
  int   exp_ill = 0;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
    exp_t e;
    case (w[6:0])
      7'h33: e.mode = 1;
      7'h13: e.mode = 2;
      7'h03: e.mode = 3;
      7'h23: e.mode = 4;
      7'h63: e.mode = 5;
      7'h6F: e.mode = 6;
      7'h37: e.mode = 7;
      7'h17: e.mode = 8;
      7'h67: e.mode = 10;
      7'h00: e.mode = 0;
      default: e.mode = 9;
    endcase
    e.rd  = (e.mode inside {1, 2, 3, 6, 7, 8, 10}) ? w[11:7]  : 5'd0;
    e.rs1 = (e.mode inside {1, 2, 3, 4, 5, 10})    ? w[19:15] : 5'd0;
    e.f3  = (e.mode inside {1, 2, 3, 4, 5, 10})    ? w[14:12] : 3'd0;
    e.rs2 = (e.mode inside {1, 4, 5})              ? w[24:20] : 5'd0;
    e.f7  = (e.mode inside {1, 2})                 ? w[31:25] : 7'd0;
    case (e.mode)
      2, 3, 10: e.imm = 32'($signed(w) >>> 20);
      4:        e.imm = (32'($signed(w) >>> 20) & ~32'h1F) | 32'(w[11:7]);
      5:        e.imm = (32'($signed(w) >>> 19) & ~32'hFFF) | (32'(w[7]) << 11)
                        | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
      6:        e.imm = (32'($signed(w) >>> 11) & ~32'hFFFFF) | (32'(w[19:12]) << 12)
                        | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
      7, 8:     e.imm = w & 32'hFFFFF000;
      default:  e.imm = 32'd0;
    endcase
    e.pc = pc;
    return e;
  endfunction

  task automatic check_outputs();
    check("in_ready", in_ready, q.size() < 2);
    check("out_valid", out_valid, q.size() > 0);
    if (q.size() > 0) begin
      check("mode", out_mode, q[0].mode);
      check("rd", out_rd, q[0].rd);
      check("rs1", out_rs1, q[0].rs1);
      check("rs2", out_rs2, q[0].rs2);
      check("funct3", out_funct3, q[0].f3);
      check("funct7", out_funct7, q[0].f7);
      check("imm", out_imm, q[0].imm);
      check("pc", out_pc, q[0].pc);
      check("illegal", out_illegal, q[0].mode == 9);
    end
`ifdef DECODE_STATS_EN
    check("stat_decoded", stat_decoded, exp_dec);
    check("stat_illegal", stat_illegal, exp_ill);
`endif
  endtask

  task automatic step();
    bit in_hs, out_hs;
    @(negedge clk);
    check_outputs();
    in_hs  = in_valid && (q.size() < 2);
    out_hs = out_ready && (q.size() > 0);
    @(posedge clk);
    if (out_hs) begin
      if (exp_dec < CNT_MAX) exp_dec++;
      if (q[0].mode == 9 && exp_ill < CNT_MAX) exp_ill++;
    end
    if (flush) q.delete();
    else begin
      if (out_hs) void'(q.pop_front());
      if (in_hs) q.push_back(ref_decode(in_instr, in_pc));
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_mode", out_mode, 0);
    check("rst_rd", out_rd, 0);
    check("rst_imm", out_imm, 0);
    check("rst_pc", out_pc, 0);
`ifdef DECODE_STATS_EN
    check("rst_stat_decoded", stat_decoded, 0);
    check("rst_stat_illegal", stat_illegal, 0);
`endif
    q.delete();
    exp_dec = 0;
    exp_ill = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w, input logic rdy);
    in_valid = 1'b1; in_instr = w; in_pc = $urandom; out_ready = rdy;
    step();
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0]  ops [10];
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h67, 7'h00};
    w = $urandom;
    if ($urandom_range(0, 5) != 0) w[6:0] = ops[$urandom_range(0, 9)];
    return w;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    in_instr = '0; in_pc = '0;
    do_reset();

    send(32'hFFF10093, 1'b1);
    check("addi_mode", out_mode, 2);
    check("addi_rd", out_rd, 1);
    check("addi_rs1", out_rs1, 2);
    check("addi_rs2", out_rs2, 0);
    check("addi_f3", out_funct3, 0);
    check("addi_imm", out_imm, 32'hFFFFFFFF);
    check("addi_ill", out_illegal, 0);

    send(32'h00532423, 1'b1);
    check("sw_mode", out_mode, 4);
    check("sw_rd", out_rd, 0);
    check("sw_rs1", out_rs1, 6);
    check("sw_rs2", out_rs2, 5);
    check("sw_f3", out_funct3, 2);
    check("sw_imm", out_imm, 32'h8);

    send(32'h123451B7, 1'b1);
    check("lui_mode", out_mode, 7);
    check("lui_rd", out_rd, 3);
    check("lui_imm", out_imm, 32'h12345000);

    send(32'hFFFFFFFF, 1'b1);
    check("ill_mode", out_mode, 9);
    check("ill_flag", out_illegal, 1);
    check("ill_rd", out_rd, 0);
    check("ill_rs1", out_rs1, 0);
    check("ill_f7", out_funct7, 0);
    check("ill_imm", out_imm, 0);

    send(32'h00000000, 1'b1);
    check("nop_mode", out_mode, 0);
    check("nop_ill", out_illegal, 0);
    out_ready = 1'b1;
    step();

    // A, B, C back-to-back into a stalled output
    send(32'hFFF10093, 1'b0);
    send(32'h00532423, 1'b0);
    check("skid_in_ready", in_ready, 0);
    check("skid_hold_a", out_mode, 2);
    in_valid = 1'b1; in_instr = 32'h123451B7; in_pc = 32'hC0;
    step();
    check("skid_c_stalled", in_ready, 0);
    check("skid_still_a", out_mode, 2);
    out_ready = 1'b1;
    step();
    check("order_b", out_mode, 4);
    step();
    in_valid = 1'b0;
    check("order_c", out_mode, 7);
    step();
    check("drained", out_valid, 0);

    // flush with output and skid full, then flush racing an accepted input
    send(32'h00532423, 1'b0);
    send(32'h123451B7, 1'b0);
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'hFFF10093;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    out_ready = 1'b1; flush = 1'b1; in_valid = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_discard", out_valid, 0);
    repeat (3) step();

    // reset while stalled
    send(32'h00532423, 1'b0);
    send(32'h123451B7, 1'b0);
    do_reset();

`ifdef DECODE_STATS_EN
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) send((i % 7 == 3) ? 32'hFFFFFFFF : 32'hFFF10093, 1'b1);
    repeat (2) step();
    check("stat_sat_decoded", stat_decoded, 15);
    check("stat_illegal3", stat_illegal, 3);
    send(32'hFFFFFFFF, 1'b1);
    do_reset();
`endif

    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      in_instr  = rand_instr();
      in_pc     = $urandom;
      step();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
